formula_pipe_credit_adapter: RTL and testbench

//   Receiving end of a fixed-latency valid-only formula pipeline (arg_vld in, res_vld out, no stall).

---
 rtl/formula_credit_pkg.sv | 29 ++
 rtl/flip_flop_fifo_with_counter.sv | 83 ++++++++
 rtl/formula_pipe_credit_adapter.sv | 126 ++++++++++++
 tb/tb_formula_pipe_credit_adapter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/formula_credit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | formula_credit_pkg                                                       |
// | Shared types, default sizes and sizing helpers for the credit adapter.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package formula_credit_pkg;

   localparam int unsigned DEF_W       = 32;
   localparam int unsigned DEF_LATENCY = 12;
   localparam int unsigned DEF_DEPTH   = 16;

   typedef logic [DEF_W-1:0] data_t;

   // Counter must hold the value DEPTH itself, not just DEPTH-1.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic bit depth_ok(input int unsigned depth, input int unsigned latency);
      return depth >= latency + 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/flip_flop_fifo_with_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flip_flop_fifo_with_counter                                              |
// | Register-based FIFO with occupancy count; push+pop allowed when full.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module flip_flop_fifo_with_counter
   import formula_credit_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = ptr_w(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // A pop frees the head slot this cycle, so a full FIFO can still accept.
   assign do_pop  = pop & !empty;
   assign do_push = push & (!full | do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule
`default_nettype wire

// File: rtl/formula_pipe_credit_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | formula_pipe_credit_adapter                                              |
// | Credit-gated issue into a fixed-latency valid-only pipe with a result    |
// | FIFO; FORMULA_CREDIT_CHECK_EN adds a sticky err flag and arg-hold SVA.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module formula_pipe_credit_adapter
   import formula_credit_pkg::*;
#(
   parameter int unsigned W       = DEF_W,
   parameter int unsigned LATENCY = DEF_LATENCY,
   parameter int unsigned DEPTH   = DEF_DEPTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         up_vld,
   output logic         up_rdy,
   input  logic [W-1:0] up_a,
   input  logic [W-1:0] up_b,
   input  logic [W-1:0] up_c,
   output logic         pipe_arg_vld,
   output logic [W-1:0] pipe_a,
   output logic [W-1:0] pipe_b,
   output logic [W-1:0] pipe_c,
   input  logic         pipe_res_vld,
   input  logic [W-1:0] pipe_res,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_data,
   output logic         err
);

   localparam int unsigned     CNT_W       = cnt_w(DEPTH);
   localparam logic [CNT_W:0]  c_depth_occ = DEPTH[CNT_W:0];

   generate
      if (!depth_ok(DEPTH, LATENCY)) begin : g_depth_check
         $error("formula_pipe_credit_adapter: DEPTH must be at least LATENCY+2");
      end
   endgenerate

   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W:0]   occupancy;
   logic             fifo_empty, fifo_full, fifo_push, fifo_pop;
   logic             issue, res_ok, res_dec;

   // Every issued argument holds one credit until its result is popped.
   assign occupancy = {1'b0, inflight_q} + {1'b0, fifo_count};
   assign up_rdy    = !rst && (occupancy < c_depth_occ);

   assign issue        = up_vld & up_rdy;
   assign pipe_arg_vld = issue;
   assign pipe_a       = up_a;
   assign pipe_b       = up_b;
   assign pipe_c       = up_c;

   assign out_vld  = !fifo_empty;
   assign fifo_pop = out_vld & out_rdy;
   assign res_ok   = (inflight_q != '0);
   assign res_dec  = pipe_res_vld & res_ok;

`ifdef FORMULA_CREDIT_CHECK_EN
   assign fifo_push = pipe_res_vld & res_ok & (!fifo_full | fifo_pop);
`else
   assign fifo_push = pipe_res_vld & (!fifo_full | fifo_pop);
`endif

   always_comb begin
      case ({issue, res_dec})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= '0;
      end else begin
         inflight_q <= inflight_d;
      end
   end

   flip_flop_fifo_with_counter #(
      .WIDTH (W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_result_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (pipe_res),
      .pop       (fifo_pop),
      .pop_data  (out_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

`ifdef FORMULA_CREDIT_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q | (pipe_res_vld & (!res_ok | (fifo_full & !fifo_pop)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;

   a_up_args_held: assert property (@(posedge clk) disable iff (rst)
      (up_vld && !up_rdy) |=> ($stable(up_a) && $stable(up_b) && $stable(up_c)));
`else
   assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_formula_pipe_credit_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_formula_pipe_credit_adapter                                           |
// | Randomized bench with a model pipe (a+b+c, 12 cycles) and a queue-based  |
// | reference of credits and result timing.                                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_formula_pipe_credit_adapter;
   import formula_credit_pkg::*;

   localparam int unsigned W = 32;
   localparam int unsigned L = 12;
   localparam int unsigned D = 16;

   logic  clk, rst, up_vld, up_rdy, pipe_arg_vld, pipe_res_vld, out_vld, out_rdy, err;
   data_t up_a, up_b, up_c, pipe_a, pipe_b, pipe_c, pipe_res, out_data;
   logic  inject;

   formula_pipe_credit_adapter #(.W(W), .LATENCY(L), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .up_vld(up_vld), .up_rdy(up_rdy),
      .up_a(up_a), .up_b(up_b), .up_c(up_c),
      .pipe_arg_vld(pipe_arg_vld), .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c),
      .pipe_res_vld(pipe_res_vld), .pipe_res(pipe_res),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model formula pipe: fixed latency, shares rst with the adapter.
   logic [L-1:0] vld_sr;
   data_t        dat_sr [L];
   always @(posedge clk) begin
      if (rst) begin
         vld_sr <= '0;
      end else begin
         vld_sr    <= {vld_sr[L-2:0], pipe_arg_vld};
         dat_sr[0] <= pipe_a + pipe_b + pipe_c;
         for (int i = 1; i < int'(L); i++) dat_sr[i] <= dat_sr[i-1];
      end
   end
   assign pipe_res_vld = vld_sr[L-1] | inject;
   assign pipe_res     = dat_sr[L-1];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
      end
   endtask

   // Reference: each accepted argument is an item that becomes visible
   // LATENCY+1 cycles after issue and holds one credit until it is taken.
   typedef struct {data_t d; int unsigned rc;} item_t;
   item_t q[$];
   int    outstanding = 0;
   bit    model_err   = 0;
   int    pop_total   = 0;

   initial begin
      bit exp_rdy, exp_vld;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("up_rdy_in_rst", 64'(up_rdy), 64'(0));
            q.delete();
            outstanding = 0;
            model_err   = 0;
         end else begin
            exp_rdy = (outstanding < int'(D));
            exp_vld = (q.size() > 0) && (q[0].rc <= cyc);
            chk("up_rdy", 64'(up_rdy), 64'(exp_rdy));
            chk("pipe_arg_vld", 64'(pipe_arg_vld), 64'(up_vld && exp_rdy));
            chk("pipe_pass", 64'(pipe_a == up_a && pipe_b == up_b && pipe_c == up_c), 64'(1));
            chk("out_vld", 64'(out_vld), 64'(exp_vld));
            if (exp_vld) chk("out_data", 64'(out_data), 64'(q[0].d));
            chk("err", 64'(err), 64'(model_err));
            chk("occupancy_le_depth", 64'((32'(dut.inflight_q) + 32'(dut.fifo_count)) <= D), 64'(1));
            if (inject && outstanding == 0) model_err = 1;
            if (up_vld && exp_rdy) begin
               q.push_back('{d: data_t'(up_a + up_b + up_c), rc: cyc + L + 1});
               outstanding++;
            end
            if (exp_vld && out_rdy) begin
               void'(q.pop_front());
               outstanding--;
               pop_total++;
            end
         end
      end
   end

   bit pending = 0;

   // Called just after a rising edge; holds args while a transfer is pending.
   task automatic drive(input bit v, input bit r, output bit x);
      if (!pending) begin
         up_vld = v;
         up_a   = $urandom;
         up_b   = $urandom;
         up_c   = $urandom;
      end
      out_rdy = r;
      @(negedge clk);
      x       = up_vld && up_rdy;
      pending = up_vld && !x;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string nm);
      bit ok = 0;
      for (int k = 0; k < 300 && !ok; k++) begin
         @(negedge clk);
         if (outstanding == 0) ok = 1;
      end
      chk(nm, 64'(ok), 64'(1));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog expired t=%0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      bit x, found;
      int unsigned t0;
      int n, drops, pop0, stale;

      rst = 1; up_vld = 0; out_rdy = 0; up_a = '0; up_b = '0; up_c = '0; inject = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("post_rst_up_rdy", 64'(up_rdy), 64'(1));
      chk("post_rst_out_vld", 64'(out_vld), 64'(0));
      chk("post_rst_err", 64'(err), 64'(0));
      chk("post_rst_inflight", 64'(dut.inflight_q), 64'(0));

      // Single literal transaction pins latency and the formula.
      @(posedge clk); #1;
      out_rdy = 1; up_vld = 1; up_a = 1; up_b = 2; up_c = 3;
      @(negedge clk);
      t0 = cyc;
      chk("pin_issue", 64'(up_rdy), 64'(1));
      @(posedge clk); #1;
      up_vld = 0;
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (out_vld) found = 1;
      end
      chk("pin_found", 64'(found), 64'(1));
      chk("pin_latency", 64'(cyc - t0), 64'(13));
      chk("pin_data", 64'(out_data), 64'(6));
      @(posedge clk); #1;

      // Full-rate stream.
      pop0 = pop_total; drops = 0; n = 0;
      for (int g = 0; g < 400 && n < 100; g++) begin
         drive(1, 1, x);
         if (x) n++; else drops++;
      end
      up_vld = 0; pending = 0;
      wait_idle("stream_idle");
      chk("stream_issued", 64'(n), 64'(100));
      chk("stream_pops", 64'(pop_total - pop0), 64'(100));
      chk("stream_rdy_drops", 64'(drops), 64'(0));

      // Back-pressure: credits run out at exactly DEPTH.
      n = 0;
      for (int g = 0; g < 30; g++) begin
         drive(1, 0, x);
         if (x) n++;
      end
      chk("stall_issues", 64'(n), 64'(16));
      chk("stall_up_rdy", 64'(up_rdy), 64'(0));
      up_vld = 0; pending = 0;
      pop0 = pop_total;
      out_rdy = 1;
      wait_idle("drain_idle");
      chk("drain_pops", 64'(pop_total - pop0), 64'(16));
      chk("drain_up_rdy", 64'(up_rdy), 64'(1));

      // Random traffic.
      for (int g = 0; g < 2000; g++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), x);
      end
      up_vld = 0; pending = 0; out_rdy = 1;
      wait_idle("random_idle");

      // Reset with 3 buffered and 5 in flight.
      repeat (3) drive(1, 0, x);
      up_vld = 0;
      repeat (14) drive(0, 0, x);
      repeat (5) drive(1, 0, x);
      up_vld = 0; pending = 0;
      chk("pre_rst_buffered", 64'(dut.fifo_count), 64'(3));
      chk("pre_rst_inflight", 64'(dut.inflight_q), 64'(5));
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("mid_rst_out_vld", 64'(out_vld), 64'(0));
      chk("mid_rst_inflight", 64'(dut.inflight_q), 64'(0));
      chk("mid_rst_count", 64'(dut.fifo_count), 64'(0));
      out_rdy = 1; stale = 0;
      repeat (30) begin
         @(negedge clk);
         if (out_vld) stale++;
      end
      chk("mid_rst_no_stale", 64'(stale), 64'(0));
      @(posedge clk); #1;

`ifdef FORMULA_CREDIT_CHECK_EN
      inject = 1;
      @(posedge clk); #1;
      inject = 0;
      @(negedge clk);
      chk("err_set", 64'(err), 64'(1));
      repeat (5) @(negedge clk);
      chk("err_sticky", 64'(err), 64'(1));
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("err_cleared", 64'(err), 64'(0));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
